// File: rtl/cordic_pkg.sv
// cordic_pkg: constants, state encoding and operand checks
// shared by the hyperbolic CORDIC request scheduler.
package cordic_pkg;

  localparam int Q_W    = 16;
  localparam int Q_FRAC = 13;
  localparam int FN_W   = 4;
  localparam int RES_W  = 32;

  localparam logic [FN_W-1:0] FN_SINH = 4'd4;
  localparam logic [FN_W-1:0] FN_COSH = 4'd5;
  localparam logic [FN_W-1:0] FN_EXP  = 4'd6;

  // 1.1182 in Q2.13: hyperbolic CORDIC convergence limit
  localparam logic signed [Q_W-1:0] HYP_X_MAX = 16'sh23C8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } sched_st_e;

  function automatic logic fn_legal(input logic [FN_W-1:0] f);
    return (f == FN_SINH) || (f == FN_COSH) || (f == FN_EXP);
  endfunction

  function automatic logic x_in_range(
    input logic signed [Q_W-1:0] x
  );
    return (x <= HYP_X_MAX) && (x >= -HYP_X_MAX);
  endfunction

endpackage

// File: rtl/cordic_rr_arb.sv
// cordic_rr_arb: round-robin pick of the first request at or
// after the rotating pointer; pointer advances past each grant.
module cordic_rr_arb #(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_i,
  input  logic                    adv_i,
  output logic                    any_o,
  output logic [$clog2(NREQ)-1:0] idx_o
);

  localparam int IDW = $clog2(NREQ);
  localparam int SW  = IDW + 1;

  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  ptr_d;
  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  off;
  logic [SW-1:0]   sum;

  // rot[k] is the request k places after the pointer
  always_comb begin
    rot = NREQ'({req_i, req_i} >> ptr_q);
    any_o = |rot;
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IDW'(k);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
    idx_o = sum[IDW-1:0];
  end

  always_comb begin
    if (idx_o == IDW'(NREQ - 1)) ptr_d = '0;
    else ptr_d = idx_o + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (adv_i) ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cordic_hyp_sched.sv
// cordic_hyp_sched: shares one hyperbolic CORDIC core among NREQ
// requesters. Define CORDIC_SCHED_RANGE_CHK_EN to reject |x| > 1.1182.
module cordic_hyp_sched
  import cordic_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*16-1:0]      req_x,
  input  logic [NREQ*4-1:0]       req_func,
  output logic [NREQ-1:0]         req_gnt,
  output logic                    core_st,
  output logic [15:0]             core_x,
  output logic [3:0]              core_func,
  input  logic                    core_done,
  input  logic [31:0]             core_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [31:0]             rsp_result,
  output logic                    rsp_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(TIMEOUT_CYC) + 1;

  sched_st_e       state_q;
  logic [NREQ-1:0] gnt_q;
  logic            st_q;
  logic [Q_W-1:0]  x_q;
  logic [FN_W-1:0] fn_q;
  logic [IDW-1:0]  id_q;
  logic            vld_q;
  logic            err_q;
  logic [RES_W-1:0] res_q;
  logic [CW-1:0]   cnt_q;

  logic            any_req;
  logic [IDW-1:0]  pick;
  logic            grant;
  logic [Q_W-1:0]  x_sel;
  logic [FN_W-1:0] fn_sel;
  logic            issue_ok;

  assign grant = (state_q == ST_IDLE) && any_req;

  cordic_rr_arb #(
    .NREQ(NREQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .adv_i (grant),
    .any_o (any_req),
    .idx_o (pick)
  );

  always_comb begin
    x_sel  = '0;
    fn_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IDW'(i)) begin
        x_sel  = req_x[16*i +: 16];
        fn_sel = req_func[4*i +: 4];
      end
    end
  end

`ifdef CORDIC_SCHED_RANGE_CHK_EN
  assign issue_ok = fn_legal(fn_q) && x_in_range(x_q);
`else
  assign issue_ok = fn_legal(fn_q);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      st_q    <= 1'b0;
      x_q     <= '0;
      fn_q    <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      gnt_q <= '0;
      st_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << pick;
            x_q     <= x_sel;
            fn_q    <= fn_sel;
            id_q    <= pick;
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (issue_ok) begin
            st_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_WAIT;
          end else begin
            err_q   <= 1'b1;
            res_q   <= '0;
            vld_q   <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (core_done) begin
            res_q   <= core_result;
            err_q   <= 1'b0;
            vld_q   <= 1'b1;
            state_q <= ST_RESP;
          end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            res_q   <= '0;
            err_q   <= 1'b1;
            vld_q   <= 1'b1;
            state_q <= ST_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            vld_q   <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_gnt    = gnt_q;
  assign core_st    = st_q;
  assign core_x     = x_q;
  assign core_func  = fn_q;
  assign rsp_valid  = vld_q;
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_cordic_hyp_sched.sv
// tb_cordic_hyp_sched: scenario tasks plus a randomized run checked
// against a queue-based round-robin / response model.
module tb_cordic_hyp_sched;

  localparam int NREQ = 4;
  localparam int TO   = 64;
  localparam logic [11:0] TAG = 12'hA5C;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*16-1:0] req_x;
  logic [NREQ*4-1:0] req_func;
  logic [NREQ-1:0]   req_gnt;
  logic              core_st;
  logic [15:0]       core_x;
  logic [3:0]        core_func;
  logic              core_done;
  logic [31:0]       core_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [31:0]       rsp_result;
  logic              rsp_err;

  cordic_hyp_sched #(
    .NREQ(NREQ),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_x       (req_x),
    .req_func    (req_func),
    .req_gnt     (req_gnt),
    .core_st     (core_st),
    .core_x      (core_x),
    .core_func   (core_func),
    .core_done   (core_done),
    .core_result (core_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_err     (rsp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        err;
    int          c;
  } rsp_t;

  rsp_t rsp_q[$];
  int   gnt_q[$];
  int   gnt_cyc_q[$];
  int   st_cyc_q[$];
  int   vrise_q[$];
  int   gnt_multi = 0;
  logic prev_valid = 1'b0;

  int          core_cnt = 0;
  bit          core_hang = 0;
  bit          hang_rand = 0;
  bit          fixed_en = 0;
  logic [31:0] fixed_val = '0;
  int          fixed_lat = 0;
  logic [31:0] pend_val = '0;
  bit          hold_all = 0;

  function automatic int rr_pick(input logic [NREQ-1:0] p, input int rr);
    for (int k = 0; k < NREQ; k++)
      if (p[(rr + k) % NREQ]) return (rr + k) % NREQ;
    return -1;
  endfunction

  function automatic bit exp_err(input logic [3:0] f,
                                 input logic signed [15:0] x,
                                 input bit hang);
    bit e;
    e = !(f inside {4'd4, 4'd5, 4'd6});
`ifdef CORDIC_SCHED_RANGE_CHK_EN
    if (x > 16'sh23C8 || x < -16'sh23C8) e = 1;
`endif
    if (!e && hang) e = 1;
    return e;
  endfunction

  // Monitor the current cycle, advance one clock, then play core/requesters.
  task automatic step();
    if (|req_gnt) begin
      for (int i = 0; i < NREQ; i++)
        if (req_gnt[i]) gnt_q.push_back(i);
      gnt_cyc_q.push_back(cyc);
      if ($countones(req_gnt) != 1) gnt_multi++;
    end
    if (core_st) st_cyc_q.push_back(cyc);
    if (rsp_valid && !prev_valid) vrise_q.push_back(cyc);
    prev_valid = rsp_valid;
    if (rsp_valid && rsp_ready)
      rsp_q.push_back('{int'(rsp_id), rsp_result, rsp_err, cyc});
    @(posedge clk);
    #1;
    cyc++;
    core_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        core_done = 1'b1;
        core_result = pend_val;
      end
    end
    if (core_st && !core_hang && !(hang_rand && core_x[3:0] == 4'hF)) begin
      pend_val = fixed_en ? fixed_val : {TAG, core_func, core_x};
      core_cnt = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 20));
    end
    if (!hold_all) req = req & ~req_gnt;
  endtask

  task automatic clear_mon();
    rsp_q.delete();
    gnt_q.delete();
    gnt_cyc_q.delete();
    st_cyc_q.delete();
    vrise_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    core_cnt = 0;
    core_done = 1'b0;
    hold_all = 0;
    core_hang = 0;
    hang_rand = 0;
    rsp_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    clear_mon();
  endtask

  task automatic run_one(input int id, input logic [15:0] x,
                         input logic [3:0] f, input int budget);
    int n0;
    n0 = rsp_q.size();
    req_x[16*id +: 16] = x;
    req_func[4*id +: 4] = f;
    req[id] = 1'b1;
    for (int k = 0; k < budget && rsp_q.size() == n0; k++) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    total++; if (req_gnt !== '0) begin bad++; $display("FAIL rst_gnt: got %b want 0", req_gnt); end
    total++; if (core_st !== 1'b0) begin bad++; $display("FAIL rst_st: got %b want 0", core_st); end
    total++; if (core_x !== '0) begin bad++; $display("FAIL rst_x: got %h want 0", core_x); end
    total++; if (core_func !== '0) begin bad++; $display("FAIL rst_func: got %h want 0", core_func); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_id !== '0) begin bad++; $display("FAIL rst_id: got %0d want 0", rsp_id); end
    total++; if (rsp_result !== '0) begin bad++; $display("FAIL rst_res: got %h want 0", rsp_result); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", rsp_err); end
  endtask

  task automatic test_single();
    do_reset();
    rsp_ready = 1'b1;
    fixed_en = 1; fixed_val = 32'h2000; fixed_lat = 16;
    run_one(0, 16'h0000, 4'd6, 100);
    total++;
    if (rsp_q.size() != 1 || st_cyc_q.size() != 1 || gnt_q.size() != 1) begin
      bad++;
      $display("FAIL single_cnt: got rsp=%0d st=%0d gnt=%0d want 1 each",
               rsp_q.size(), st_cyc_q.size(), gnt_q.size());
    end else begin
      total++; if (gnt_q[0] != 0) begin bad++; $display("FAIL single_gnt: got %0d want 0", gnt_q[0]); end
      total++; if (st_cyc_q[0] != gnt_cyc_q[0] + 1) begin bad++; $display("FAIL single_st_lat: got %0d want %0d", st_cyc_q[0] - gnt_cyc_q[0], 1); end
      total++; if (vrise_q[0] != st_cyc_q[0] + 17) begin bad++; $display("FAIL single_rsp_lat: got %0d want 17", vrise_q[0] - st_cyc_q[0]); end
      total++; if (rsp_q[0].id != 0 || rsp_q[0].err !== 1'b0) begin bad++; $display("FAIL single_id_err: got id=%0d err=%b want 0/0", rsp_q[0].id, rsp_q[0].err); end
      total++; if (rsp_q[0].res !== 32'h0000_2000) begin bad++; $display("FAIL single_res: got %h want 00002000", rsp_q[0].res); end
      total++; if (core_x !== 16'h0 || core_func !== 4'd6) begin bad++; $display("FAIL single_latch: got x=%h f=%0d want 0/6", core_x, core_func); end
    end
  endtask

  task automatic test_rotation();
    int rr;
    int e;
    do_reset();
    rsp_ready = 1'b1;
    fixed_en = 1; fixed_val = 32'h55; fixed_lat = 5;
    for (int i = 0; i < NREQ; i++) begin
      req_x[16*i +: 16] = 16'(i * 256);
      req_func[4*i +: 4] = 4'd5;
    end
    hold_all = 1;
    req = '1;
    for (int k = 0; k < 200 && gnt_q.size() < 5; k++) step();
    hold_all = 0;
    req = '0;
    repeat (20) step();
    total++;
    if (gnt_q.size() < 5) begin
      bad++;
      $display("FAIL rot_cnt: got %0d grants want 5", gnt_q.size());
    end else begin
      rr = 0;
      for (int k = 0; k < 5; k++) begin
        e = rr_pick('1, rr);
        rr = (e + 1) % NREQ;
        total++;
        if (gnt_q[k] != e) begin bad++; $display("FAIL rot_order%0d: got %0d want %0d", k, gnt_q[k], e); end
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (gnt_cyc_q[k+1] - gnt_cyc_q[k] != fixed_lat + 4) begin
          bad++;
          $display("FAIL rot_gap%0d: got %0d want %0d", k, gnt_cyc_q[k+1] - gnt_cyc_q[k], fixed_lat + 4);
        end
      end
    end
  endtask

  task automatic test_illegal();
    int n_st;
    do_reset();
    rsp_ready = 1'b1;
    fixed_en = 1; fixed_val = 32'hDEAD_BEEF; fixed_lat = 3;
    run_one(1, 16'h0100, 4'd4, 50);
    n_st = st_cyc_q.size();
    run_one(2, 16'h0100, 4'd3, 50);
    total++;
    if (rsp_q.size() != 2) begin
      bad++; $display("FAIL ill_cnt: got %0d want 2", rsp_q.size());
    end else begin
      total++; if (st_cyc_q.size() != n_st) begin bad++; $display("FAIL ill_st: got %0d starts want %0d", st_cyc_q.size(), n_st); end
      total++; if (rsp_q[1].id != 2) begin bad++; $display("FAIL ill_id: got %0d want 2", rsp_q[1].id); end
      total++; if (rsp_q[1].err !== 1'b1 || rsp_q[1].res !== 32'h0) begin bad++; $display("FAIL ill_err_res: got %b/%h want 1/0", rsp_q[1].err, rsp_q[1].res); end
    end
  endtask

  task automatic test_timeout();
    int n_st;
    int n_v;
    int n_r;
    rsp_ready = 1'b1;
    fixed_en = 1; fixed_val = 32'hCAFE_0001; fixed_lat = 3;
    run_one(0, 16'h0040, 4'd4, 50);
    core_hang = 1;
    n_st = st_cyc_q.size(); n_v = vrise_q.size(); n_r = rsp_q.size();
    run_one(3, 16'h0100, 4'd5, 200);
    core_hang = 0;
    total++;
    if (rsp_q.size() != n_r + 1 || st_cyc_q.size() != n_st + 1 || vrise_q.size() != n_v + 1) begin
      bad++; $display("FAIL to_cnt: got rsp=%0d want %0d", rsp_q.size(), n_r + 1);
    end else begin
      total++; if (vrise_q[n_v] - st_cyc_q[n_st] != TO) begin bad++; $display("FAIL to_lat: got %0d want %0d", vrise_q[n_v] - st_cyc_q[n_st], TO); end
      total++; if (rsp_q[n_r].err !== 1'b1 || rsp_q[n_r].res !== 32'h0 || rsp_q[n_r].id != 3) begin
        bad++; $display("FAIL to_rsp: got err=%b res=%h id=%0d want 1/0/3", rsp_q[n_r].err, rsp_q[n_r].res, rsp_q[n_r].id);
      end
    end
  endtask

  task automatic test_backpressure();
    int sid;
    logic [31:0] sres;
    logic serr;
    int n_g;
    int hs;
    rsp_ready = 1'b0;
    fixed_en = 0; fixed_lat = 4;
    req_x[16 +: 16] = 16'h0123; req_func[4 +: 4] = 4'd5; req[1] = 1'b1;
    for (int k = 0; k < 50 && !rsp_valid; k++) step();
    sid = int'(rsp_id); sres = rsp_result; serr = rsp_err;
    total++;
    if (!rsp_valid || sid != 1 || serr !== 1'b0 || sres !== {TAG, 4'd5, 16'h0123}) begin
      bad++; $display("FAIL bp_first: got v=%b id=%0d err=%b res=%h want 1/1/0/%h", rsp_valid, sid, serr, sres, {TAG, 4'd5, 16'h0123});
    end
    req_x[32 +: 16] = 16'h0456; req_func[8 +: 4] = 4'd4; req[2] = 1'b1;
    n_g = gnt_q.size();
    for (int k = 0; k < 10; k++) begin
      step();
      total++;
      if (rsp_valid !== 1'b1 || int'(rsp_id) != sid || rsp_result !== sres || rsp_err !== serr) begin
        bad++; $display("FAIL bp_hold%0d: got v=%b id=%0d res=%h want 1/%0d/%h", k, rsp_valid, rsp_id, rsp_result, sid, sres);
      end
    end
    total++; if (gnt_q.size() != n_g) begin bad++; $display("FAIL bp_nogrant: got %0d grants want %0d", gnt_q.size(), n_g); end
    rsp_ready = 1'b1;
    hs = cyc;
    step();
    for (int k = 0; k < 10 && gnt_q.size() == n_g; k++) step();
    total++;
    if (gnt_q.size() != n_g + 1 || gnt_q[n_g] != 2 || gnt_cyc_q[n_g] != hs + 2) begin
      bad++; $display("FAIL bp_next: got %0d grants want 1 to id 2 at handshake+2", gnt_q.size() - n_g);
    end
    for (int k = 0; k < 60 && rsp_valid == 1'b0; k++) step();
    step();
  endtask

  task automatic test_reset_mid();
    int n_st;
    int nv;
    int ng;
    rsp_ready = 1'b1;
    fixed_en = 1; fixed_val = 32'h1234_5678; fixed_lat = 30;
    n_st = st_cyc_q.size();
    req_x[15:0] = 16'h0100; req_func[3:0] = 4'd4; req[0] = 1'b1;
    for (int k = 0; k < 20 && st_cyc_q.size() == n_st; k++) step();
    repeat (5) step();
    rst = 1'b1;
    step();
    total++;
    if ({req_gnt, core_st, core_x, core_func, rsp_valid, rsp_id, rsp_result, rsp_err} !== '0) begin
      bad++; $display("FAIL rmid_out: got x=%h f=%h v=%b res=%h want all 0", core_x, core_func, rsp_valid, rsp_result);
    end
    rst = 1'b0;
    nv = vrise_q.size(); ng = gnt_q.size();
    repeat (40) step();
    total++; if (vrise_q.size() != nv || rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %0d responses want 0", vrise_q.size() - nv); end
    total++; if (gnt_q.size() != ng || rsp_result !== '0 || core_x !== '0) begin bad++; $display("FAIL rmid_quiet: got gnt=%0d res=%h want 0/0", gnt_q.size() - ng, rsp_result); end
  endtask

  task automatic test_range();
    logic [15:0] xs[4];
    logic [3:0] f;
    bit e;
    logic [31:0] er;
    xs = '{16'h23C9, 16'h23C8, 16'hDC38, 16'hDC37};
    do_reset();
    rsp_ready = 1'b1;
    fixed_en = 0; fixed_lat = 3;
    for (int i = 0; i < 4; i++) begin
      f = 4'(4 + i % 3);
      run_one(3, xs[i], f, 100);
      e = exp_err(f, xs[i], 0);
      er = e ? 32'h0 : {TAG, f, xs[i]};
      total++;
      if (rsp_q.size() != i + 1) begin
        bad++; $display("FAIL range_cnt%0d: got %0d want %0d", i, rsp_q.size(), i + 1);
      end else if (rsp_q[i].err !== e || rsp_q[i].res !== er) begin
        bad++; $display("FAIL range%0d: got err=%b res=%h want %b/%h", i, rsp_q[i].err, rsp_q[i].res, e, er);
      end
    end
  endtask

  task automatic test_random();
    int rr_m;
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] pend;
    logic [15:0] xv[NREQ];
    logic [3:0] fv[NREQ];
    int exp_id[$];
    int n0;
    int g0;
    int k;
    bit e;
    logic [31:0] er;
    do_reset();
    rr_m = 0;
    fixed_en = 0; fixed_lat = 0; hang_rand = 1;
    for (int r = 0; r < 30; r++) begin
      exp_id.delete();
      mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        fv[i] = ($urandom % 5 == 0) ? 4'($urandom) : 4'($urandom_range(4, 6));
        xv[i] = ($urandom % 6 == 0) ? 16'($urandom) : 16'($urandom_range(0, 18320)) - 16'd9160;
        req_x[16*i +: 16] = xv[i];
        req_func[4*i +: 4] = fv[i];
      end
      pend = mask;
      while (pend != '0) begin
        k = rr_pick(pend, rr_m);
        exp_id.push_back(k);
        pend[k] = 1'b0;
        rr_m = (k + 1) % NREQ;
      end
      n0 = rsp_q.size(); g0 = gnt_q.size();
      req = mask;
      for (int c = 0; c < 600 && rsp_q.size() < n0 + exp_id.size(); c++) begin
        rsp_ready = ($urandom % 4) != 0;
        step();
      end
      rsp_ready = 1'b1;
      total++;
      if (rsp_q.size() != n0 + exp_id.size() || gnt_q.size() != g0 + exp_id.size()) begin
        bad++; $display("FAIL rand_cnt%0d: got %0d responses want %0d", r, rsp_q.size() - n0, exp_id.size());
        req = '0;
        do_reset();
        rr_m = 0;
        hang_rand = 1;
      end else begin
        foreach (exp_id[j]) begin
          k = exp_id[j];
          e = exp_err(fv[k], xv[k], xv[k][3:0] == 4'hF);
          er = e ? 32'h0 : {TAG, fv[k], xv[k]};
          total++;
          if (gnt_q[g0 + j] != k) begin bad++; $display("FAIL rand_gnt%0d_%0d: got %0d want %0d", r, j, gnt_q[g0 + j], k); end
          total++;
          if (rsp_q[n0 + j].id != k || rsp_q[n0 + j].err !== e || rsp_q[n0 + j].res !== er) begin
            bad++; $display("FAIL rand_rsp%0d_%0d: got id=%0d err=%b res=%h want %0d/%b/%h", r, j, rsp_q[n0 + j].id, rsp_q[n0 + j].err, rsp_q[n0 + j].res, k, e, er);
          end
        end
      end
    end
    hang_rand = 0;
    total++; if (gnt_multi != 0) begin bad++; $display("FAIL gnt_onehot: got %0d multi-hot grants want 0", gnt_multi); end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    req_x = '0;
    req_func = '0;
    core_done = 1'b0;
    core_result = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_rotation();
    test_illegal();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_range();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

endmodule
